// File: rtl/fifo_uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package fifo_uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_W_DEF       = 8;

    function automatic int baud_cnt_w(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

    localparam int BAUD_CNT_W_DEF = baud_cnt_w(CLKS_PER_BIT_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter for the UART transmitter; bit_end ticks on the last cycle of each bit.
// Latency: bit_end is combinational from the counter, CLKS_PER_BIT cycles after clear/enable.
// Backpressure: none; counts only while en is high.
module uart_baud_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam int CNT_W = baud_cnt_w(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign bit_end = en && (cnt == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls bytes from a synchronous FIFO and serialises them 8N1 (even parity with UART_TX_PARITY_EN).
// Latency: first start-bit cycle on tx two cycles after fifo_rd; frame_done on return to IDLE.
// Backpressure: reads only from IDLE when tx_en=1 and the FIFO is non-empty; one read per frame.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [IDX_W-1:0]  bit_idx;
    logic              bit_end;
    logic              baud_en;
    logic              tx_nxt;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
`endif

    assign baud_en = (state != ST_IDLE) && (state != ST_LOAD);

    // Counter restarts on the read cycle so START begins at count 0.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (fifo_rd),
        .en      (baud_en),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (tx_en && !fifo_empty) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_START;
            ST_START: if (bit_end) state_nxt = ST_DATA;
`ifdef UART_TX_PARITY_EN
            ST_DATA:   if (bit_end && bit_idx == IDX_LAST) state_nxt = ST_PARITY;
            ST_PARITY: if (bit_end) state_nxt = ST_STOP;
`else
            ST_DATA:  if (bit_end && bit_idx == IDX_LAST) state_nxt = ST_STOP;
`endif
            ST_STOP:  if (bit_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // tx is registered from the value the next state will present, keeping the line glitch-free.
    always_comb begin
        fifo_rd   = rst_n && (state == ST_IDLE) && tx_en && !fifo_empty;
        busy      = (state != ST_IDLE) || fifo_rd;
        shreg_nxt = shreg;
        if (state == ST_LOAD) begin
            shreg_nxt = fifo_data;
        end else if (state == ST_DATA && bit_end) begin
            shreg_nxt = shreg >> 1;
        end
        tx_nxt = 1'b1;
        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_nxt = par_q;
`endif
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx         <= 1'b1;
            shreg      <= '0;
            bit_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            tx         <= tx_nxt;
            shreg      <= shreg_nxt;
            frame_done <= (state == ST_STOP) && bit_end;
            if (state == ST_LOAD) begin
                bit_idx <= '0;
            end else if (state == ST_DATA && bit_end) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (state == ST_LOAD) begin
            par_q <= ^fifo_data;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4, DATA_W=8 with a small FIFO model.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = 11;
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = 10;
`endif
    localparam int END_C = 2 + NB * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_en = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          tx;
    logic          busy;
    logic          frame_done;

    logic [7:0] mem [0:31];
    logic [4:0] wr_ptr = '0;
    logic [4:0] rd_ptr = '0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;
    vec_t tbl [12];

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous FIFO: data appears the cycle after the read pulse.
    always @(posedge clk) begin
        if (fifo_rd && wr_ptr != rd_ptr) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 5'd1;
        end
    end
    assign fifo_empty = (wr_ptr == rd_ptr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    function automatic logic exp_bit(input logic [9:0] fr, input logic par, input int b);
        logic [9:0] t;
        if (PAR && b == NB - 2) return par;
        if (PAR && b == NB - 1) return fr[9];
        t = fr >> b;
        return t[0];
    endfunction

    task automatic check_frame(input logic [9:0] fr, input logic par, input int drop_at,
                               input string nm, output int start_cyc);
        int         n;
        int         b;
        logic [10:0] obs;
        logic [10:0] expv;
        logic [10:0] t;
        logic        unstable;
        logic        rd_bad;
        logic        done_early;
        logic        busy_low;
        n = 0; obs = '0; expv = '0;
        unstable = 1'b0; rd_bad = 1'b0; done_early = 1'b0; busy_low = 1'b0;
        for (int i = 0; i < NB; i++) expv = expv | (11'(exp_bit(fr, par, i)) << i);
        #1;
        while (fifo_rd !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " fifo_rd"}, 32'(fifo_rd), 32'd1);
        chk({nm, " busy on rd"}, 32'(busy), 32'd1);
        start_cyc = cyc;
        for (int c = 1; c <= END_C; c++) begin
            @(negedge clk);
            if (c < END_C) begin
                if (fifo_rd !== 1'b0) rd_bad = 1'b1;
                if (frame_done !== 1'b0) done_early = 1'b1;
                if (busy !== 1'b1) busy_low = 1'b1;
            end
            if (c >= 2 && c < END_C) begin
                b = (c - 2) / CPB;
                if ((c - 2) % CPB == 0) begin
                    obs = obs | (11'(tx) << b);
                end else begin
                    t = obs >> b;
                    if (tx !== t[0]) unstable = 1'b1;
                end
            end
            if (c == drop_at) tx_en = 1'b0;
        end
        chk({nm, " tx bits"}, 32'(obs), 32'(expv));
        chk({nm, " bit held"}, 32'(unstable), 32'd0);
        chk({nm, " extra fifo_rd"}, 32'(rd_bad), 32'd0);
        chk({nm, " early frame_done"}, 32'(done_early), 32'd0);
        chk({nm, " busy dropped"}, 32'(busy_low), 32'd0);
        chk({nm, " frame_done"}, 32'(frame_done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int   s1;
        int   s2;
        int   n;
        logic f_rd;
        logic f_tx;
        logic f_busy;

        tbl[0]  = '{8'hA5, 10'b1101001010, 1'b0};
        tbl[1]  = '{8'h00, 10'b1000000000, 1'b0};
        tbl[2]  = '{8'hFF, 10'b1111111110, 1'b0};
        tbl[3]  = '{8'h55, 10'b1010101010, 1'b0};
        tbl[4]  = '{8'h07, 10'b1000001110, 1'b1};
        tbl[5]  = '{8'h03, 10'b1000000110, 1'b0};
        tbl[6]  = '{8'h01, 10'b1000000010, 1'b1};
        tbl[7]  = '{8'h80, 10'b1100000000, 1'b1};
        tbl[8]  = '{8'hFF, 10'b1111111110, 1'b0};
        tbl[9]  = '{8'hC3, 10'b1110000110, 1'b0};
        tbl[10] = '{8'h3C, 10'b1001111000, 1'b0};
        tbl[11] = '{8'h11, 10'b1000100010, 1'b0};

        // Reset held with data waiting and tx_en high: nothing may move.
        rst_n = 1'b0;
        tx_en = 1'b1;
        push(tbl[0].data);
        repeat (3) @(negedge clk);
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset fifo_rd", 32'(fifo_rd), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (i > 0) push(tbl[i].data);
            check_frame(tbl[i].frame, tbl[i].par, -1, $sformatf("vec%0d", i), s1);
        end

        // Back-to-back frames.
        push(tbl[6].data);
        push(tbl[7].data);
        check_frame(tbl[6].frame, tbl[6].par, -1, "b2b first", s1);
        check_frame(tbl[7].frame, tbl[7].par, -1, "b2b second", s2);
        chk("b2b read spacing", 32'(s2 - s1), 32'(END_C));

        // Empty FIFO with tx_en high.
        f_rd = 1'b0; f_tx = 1'b0; f_busy = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0) f_rd = 1'b1;
            if (tx !== 1'b1) f_tx = 1'b1;
            if (busy !== 1'b0) f_busy = 1'b1;
        end
        chk("empty fifo_rd", 32'(f_rd), 32'd0);
        chk("empty tx", 32'(f_tx), 32'd0);
        chk("empty busy", 32'(f_busy), 32'd0);

        // One-cycle reset during data bit 3 of 0xFF.
        push(tbl[8].data);
        #1;
        n = 0;
        while (fifo_rd !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("abort fifo_rd", 32'(fifo_rd), 32'd1);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort tx", 32'(tx), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        f_tx = 1'b0; f_rd = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (frame_done !== 1'b0) f_rd = 1'b1;
            if (tx !== 1'b1) f_tx = 1'b1;
        end
        chk("abort no frame_done", 32'(f_rd), 32'd0);
        chk("abort line idle", 32'(f_tx), 32'd0);
        push(tbl[9].data);
        check_frame(tbl[9].frame, tbl[9].par, -1, "after abort", s1);

        // tx_en dropped during START: frame finishes, no further reads.
        push(tbl[10].data);
        push(tbl[11].data);
        check_frame(tbl[10].frame, tbl[10].par, 3, "tx_en drop", s1);
        f_rd = 1'b0; f_tx = 1'b0;
        if (fifo_rd !== 1'b0) f_rd = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0) f_rd = 1'b1;
            if (tx !== 1'b1) f_tx = 1'b1;
        end
        chk("disabled fifo_rd", 32'(f_rd), 32'd0);
        chk("disabled tx", 32'(f_tx), 32'd0);
        chk("disabled fifo kept", 32'(fifo_empty), 32'd0);
        tx_en = 1'b1;
        check_frame(tbl[11].frame, tbl[11].par, -1, "re-enable", s1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_W, default 8: byte width read from the FIFO.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-005 tx_en  input  1  transmit enable; gates the start of new frames only.
REQ-006 fifo_empty  input  1  empty flag from the upstream synchronous FIFO.
REQ-007 fifo_data  input  DATA_W  FIFO read data; valid on the cycle after a fifo_rd pulse.
REQ-008 fifo_rd  output  1  single-cycle FIFO read request.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 busy  output  1  high from the fifo_rd cycle through the last stop-bit cycle.
REQ-011 frame_done  output  1  one-cycle pulse after the stop bit completes.

Function
REQ-012 States SHALL be IDLE, LOAD, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE: when tx_en=1 and fifo_empty=0, fifo_rd SHALL be 1 for that cycle and the next state SHALL be LOAD; otherwise the block stays in IDLE with fifo_rd=0.
REQ-014 LOAD: the block SHALL capture fifo_data into the shift register, then enter START; LOAD lasts exactly 1 cycle.
REQ-015 fifo_rd SHALL never be high on two consecutive cycles, and SHALL never be high outside IDLE; this makes the stale one-cycle fifo_empty harmless.
REQ-016 START, DATA, PARITY and STOP SHALL each hold tx for exactly CLKS_PER_BIT cycles per bit, timed by a bit counter that counts 0..CLKS_PER_BIT-1 and then wraps to 0.
REQ-017 Bit values on tx: START=0; DATA = DATA_W bits, LSB first; STOP=1.
REQ-018 The frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles, or (DATA_W+3)*CLKS_PER_BIT cycles with parity.
REQ-019 tx SHALL be driven from a register (glitch-free); the first START cycle on tx is 2 cycles after the fifo_rd cycle.
REQ-020 frame_done SHALL pulse on the cycle the state returns to IDLE; in that same cycle IDLE may issue fifo_rd, so back-to-back frames have no idle bit time.
REQ-021 tx_en deasserted mid-frame: the current frame completes; no new fifo_rd is issued.
REQ-022 fifo_empty is ignored outside IDLE.

Reset
REQ-023 With rst_n=0 at a clock edge: state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, bit and baud counters=0, shift register=0.
REQ-024 Reset mid-frame SHALL abort the frame and drive tx=1 from the next edge; the byte in flight is lost and no frame_done is produced.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, a PARITY state between DATA and STOP SHALL transmit the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles.
REQ-026 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA goes directly to STOP.

Structure
REQ-027 Shared package fifo_uart_pkg SHALL hold the state enum type, the default CLKS_PER_BIT and DATA_W constants, and the counter width derived via $clog2(CLKS_PER_BIT).
REQ-028 Sub-module uart_baud_gen SHALL hold the bit-period counter and emit a one-cycle bit_end tick; it is cleared on entry to LOAD and by reset.

Verification (CLKS_PER_BIT=4, DATA_W=8)
REQ-029 FIFO holds 0xA5, tx_en=1 -> one fifo_rd pulse; tx pattern 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; frame_done at cycle 42 after fifo_rd.
REQ-030 FIFO holds 0x01,0x80 -> two frames with no idle gap; exactly 2 fifo_rd pulses, 42 cycles apart.
REQ-031 fifo_empty=1 for 100 cycles with tx_en=1 -> fifo_rd=0, tx=1, busy=0 throughout.
REQ-032 rst_n=0 for 1 cycle during DATA bit 3 of 0xFF -> tx=1 from the next edge, no frame_done, next frame correct.
REQ-033 tx_en dropped during START of 0x3C -> full frame sent, no further fifo_rd while tx_en=0.
REQ-034 UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 after DATA; frame is 11 bits (44 cycles); with byte 0x03 the parity bit is 0.
